mobius_iter: RTL and testbench
==============================

Name: mobius_iter

Overview:
- Sequential, folded successor to the fully unrolled combinational binary Möbius transform.
- Holds one N-bit vector in a state register and applies STAGES_PER_CYCLE butterfly stages per clock, so a full transform takes LOG2_N/STAGES_PER_CYCLE cycles.
- Adds a valid/ready handshake on both sides, output back-pressure, and a per-transform mode select (subset/ANF transform or superset/dual transform).
- Sits between a vector source and a consumer in the GF(2) transform datapath.

Parameters:
- N, 2048, vector length in bits; power of two, ≥ 2.
- LOG2_N, 11, log2(N); must equal $clog2(N).
- STAGES_PER_CYCLE, 1, butterfly stages applied per clock. Must divide LOG2_N; otherwise elaboration error.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, synchronous active-low reset.
- in_valid, input, 1, in_data/in_mode valid.
- in_ready, output, 1, block can accept a vector.
- in_data, input, [0:N-1], vector to transform; bit index 0 is element 0.
- in_mode, input, 1, 0 = subset transform, 1 = superset transform; captured with in_data.
- out_valid, output, 1, out_data holds a finished result.
- out_ready, input, 1, consumer accepts out_data.
- out_data, output, [0:N-1], transformed vector.
- busy, output, 1, high in RUN or DONE.

Behaviour:
- Index convention: element i is identified with the LOG2_N-bit binary value of i. Stage s (0..LOG2_N-1) uses h = N >> (s+1).
- Subset stage s, mode 0: for every i with (i mod 2h) ≥ h, x[i] ← x[i] ^ x[i-h]. All other elements are unchanged.
- Superset stage s, mode 1: for every i with (i mod 2h) < h, x[i] ← x[i] ^ x[i+h]. All other elements are unchanged.
- Stages are applied in increasing s. Chained stages within one cycle are purely combinational.
- Full subset result: out[i] = XOR of in[j] over all j with (j & i) == j. Superset result: XOR over all j with (j & i) == i. Each mode is an involution.
- FSM states: IDLE, RUN, DONE. Registers: data_q [0:N-1], mode_q, stage_cnt of width $clog2(LOG2_N+1).
- IDLE:
  - in_ready = 1.
  - On in_valid: load data_q ← in_data, mode_q ← in_mode, stage_cnt ← 0, go to RUN.
- RUN:
  - in_ready = 0.
  - Each cycle apply stages stage_cnt .. stage_cnt+STAGES_PER_CYCLE-1 to data_q, then stage_cnt += STAGES_PER_CYCLE.
  - When the updated count equals LOG2_N, go to DONE.
- DONE:
  - out_valid = 1 and out_data = data_q, both held stable while out_ready = 0.
  - On out_ready, go to IDLE.
  - in_ready stays 0 in DONE; there is no same-cycle accept-and-return.
- Latency: handshake accepted at edge E gives out_valid high after edge E + LOG2_N/STAGES_PER_CYCLE.
- Throughput: one vector per LOG2_N/STAGES_PER_CYCLE + 2 cycles with out_ready held high.
- out_data equals data_q in every state. It is only meaningful while out_valid = 1.
- in_data and in_mode are ignored outside the IDLE accept cycle. in_valid asserted during RUN or DONE has no effect and is not queued.
- Reset (rst_n = 0 at a rising edge), including mid-RUN or in DONE:
  - state → IDLE, data_q → 0, mode_q → 0, stage_cnt → 0.
  - Outputs after reset: in_ready = 1, out_valid = 0, busy = 0, out_data = 0.
  - Any in-flight vector is discarded and never reaches the output.
- Degenerate case N = 2 (LOG2_N = 1) is supported, with latency 1.

Test Plan:
- N=8, SPC=1, mode 0, in_data=8'b1000_0000 (element 0 set) → out_data=8'b1111_1111, with out_valid rising exactly 3 cycles after accept.
- N=8, mode 0, in_data=8'b0000_0001 → 8'b0000_0001. Same input with mode 1 → 8'b1111_1111. Mode 1 with in_data=8'b1000_0000 → 8'b1000_0000.
- N=8, mode 0, in_data=8'b1100_0000 → 8'b1010_1010. Feeding that result back in with mode 0 → 8'b1100_0000 (involution).
- N=16, STAGES_PER_CYCLE=2 and 4 (LOG2_N=4), random vectors in both modes compared against the subset/superset XOR formulas → match, with latency 2 and 1 respectively.
- Back-pressure: hold out_ready=0 for 10 cycles in DONE → out_valid and out_data stable, in_ready=0, and in_valid pulses are ignored. out_ready=1 → IDLE next cycle, in_ready=1.
- Drive rst_n=0 for one cycle at stage_cnt=1 of a run → next cycle IDLE, out_valid=0, out_data=0. A new vector is then transformed correctly.

Source files
------------

// File: rtl/mobius_iter.sv
// mobius_iter: folded binary Moebius transform over GF(2).
// One N-bit vector sits in data_q and STAGES_PER_CYCLE butterfly stages are
// applied to it per clock. A full transform takes LOG2_N/STAGES_PER_CYCLE
// cycles in RUN, after which the result is held in DONE until the consumer
// takes it.
//
// Ports:
//   clk, rst_n          rising-edge clock, synchronous active-low reset
//   in_valid/in_ready   input handshake; in_data/in_mode captured on accept
//   in_data [0:N-1]     vector, bit index 0 is element 0
//   in_mode             0 = subset (ANF) transform, 1 = superset transform
//   out_valid/out_ready output handshake; out_data held while stalled
//   out_data [0:N-1]    transformed vector (mirrors data_q in every state)
//   busy                high while a vector is in RUN or DONE
//
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; valid and its payload stay stable until that edge.
module mobius_iter #(
  parameter int N                = 2048,
  parameter int LOG2_N           = 11,
  parameter int STAGES_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:N-1] in_data,
  input  logic         in_mode,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:N-1] out_data,
  output logic         busy
);

  localparam int CW = $clog2(LOG2_N + 1);

  generate
    if (N < 2 || LOG2_N != $clog2(N) || (1 << LOG2_N) != N) begin : g_bad_n
      $error("mobius_iter: N must be a power of two >= 2 with LOG2_N == $clog2(N)");
    end
    if (STAGES_PER_CYCLE < 1 || (LOG2_N % STAGES_PER_CYCLE) != 0) begin : g_bad_spc
      $error("mobius_iter: STAGES_PER_CYCLE must divide LOG2_N");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [0:N-1]  data_q;
  logic [0:N-1]  data_nxt;
  logic          mode_q;
  logic [CW-1:0] stage_cnt;
  logic [CW-1:0] cnt_nxt;
  logic          in_ready_q;
  logic          out_valid_q;
  logic          busy_q;

  // One butterfly stage s (h = N >> (s+1)). Element i pairs with i ^ h:
  // subset mode updates the member of the pair with the h bit set,
  // superset mode updates the member with the h bit clear.
  function automatic logic [0:N-1] stage_fn(input logic [0:N-1] x,
                                            input int s,
                                            input logic mode);
    logic [0:N-1] r;
    int h;
    r = x;
    h = N >> (s + 1);
    for (int i = 0; i < N; i++) begin
      if (((i & h) != 0) != mode) begin
        r[i] = x[i] ^ x[i ^ h];
      end
    end
    return r;
  endfunction

  assign cnt_nxt = stage_cnt + CW'(STAGES_PER_CYCLE);

  // Each chained slot k selects its stage with a constant-indexed match so
  // every stage is a fixed wiring pattern rather than a variable shifter.
  always_comb begin : butterfly
    logic [0:N-1] v;
    v = data_q;
    for (int k = 0; k < STAGES_PER_CYCLE; k++) begin
      for (int s = 0; s < LOG2_N; s++) begin
        if (int'(stage_cnt) + k == s) begin
          v = stage_fn(v, s, mode_q);
        end
      end
    end
    data_nxt = v;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      mode_q      <= 1'b0;
      stage_cnt   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            data_q     <= in_data;
            mode_q     <= in_mode;
            stage_cnt  <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        RUN: begin
          data_q    <= data_nxt;
          stage_cnt <= cnt_nxt;
          if (cnt_nxt == CW'(LOG2_N)) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          // No accept in this cycle: in_ready only rises once back in IDLE.
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_data  = data_q;

endmodule

// File: tb/tb_mobius_iter.sv
module tb_mobius_iter;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // instance 0: N=8 SPC=1, instance 1: N=16 SPC=2, instance 2: N=16 SPC=4
  logic [2:0]  iv, im, ordy;
  logic [2:0]  ir, ov, bz;
  logic [0:7]  d8, od8;
  logic [0:15] d16a, od16a, d16b, od16b;

  mobius_iter #(.N(8), .LOG2_N(3), .STAGES_PER_CYCLE(1)) u_n8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]),
    .in_data(d8), .in_mode(im[0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .out_data(od8), .busy(bz[0]));

  mobius_iter #(.N(16), .LOG2_N(4), .STAGES_PER_CYCLE(2)) u_n16_s2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]),
    .in_data(d16a), .in_mode(im[1]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .out_data(od16a), .busy(bz[1]));

  mobius_iter #(.N(16), .LOG2_N(4), .STAGES_PER_CYCLE(4)) u_n16_s4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]),
    .in_data(d16b), .in_mode(im[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .out_data(od16b), .busy(bz[2]));

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Direct definition: subset out[i] = XOR in[j] for j subset of i,
  // superset out[i] = XOR in[j] for j superset of i (n elements used).
  function automatic logic [0:15] model(input logic [0:15] v, input int n, input logic mode);
    logic [0:15] r;
    logic acc;
    r = '0;
    for (int i = 0; i < n; i++) begin
      acc = 1'b0;
      for (int j = 0; j < n; j++) begin
        if (mode ? ((j & i) == i) : ((j & i) == j)) acc ^= v[j];
      end
      r[i] = acc;
    end
    return r;
  endfunction

  function automatic int nsz(input int k);
    return (k == 0) ? 8 : 16;
  endfunction

  function automatic logic [0:15] get_od(input int k);
    case (k)
      0:       return {od8, 8'h00};
      1:       return od16a;
      default: return od16b;
    endcase
  endfunction

  task automatic set_din(input int k, input logic [0:15] v);
    case (k)
      0:       d8 = v[0:7];
      1:       d16a = v;
      default: d16b = v;
    endcase
  endtask

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  logic [15:0] exp_q2[$];

  task automatic q_push(input int k, input logic [15:0] v);
    case (k)
      0:       exp_q0.push_back(v);
      1:       exp_q1.push_back(v);
      default: exp_q2.push_back(v);
    endcase
  endtask

  function automatic int q_size(input int k);
    case (k)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic [15:0] q_front(input int k);
    case (k)
      0:       return exp_q0[0];
      1:       return exp_q1[0];
      default: return exp_q2[0];
    endcase
  endfunction

  task automatic q_pop(input int k);
    case (k)
      0:       void'(exp_q0.pop_front());
      1:       void'(exp_q1.pop_front());
      default: void'(exp_q2.pop_front());
    endcase
  endtask

  task automatic q_flush();
    exp_q0.delete();
    exp_q1.delete();
    exp_q2.delete();
  endtask

  // Compare process: every cycle an instance shows out_valid, its data must
  // equal the model result of the oldest accepted vector.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 3; k++) begin
        if (ov[k]) begin
          if (q_size(k) == 0) begin
            chk($sformatf("unexpected_out_valid_%0d", k), 32'd1, 32'd0);
          end else begin
            chk($sformatf("out_data_%0d", k), get_od(k), q_front(k));
            if (ordy[k]) q_pop(k);
          end
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic xfer(input int k, input logic [0:15] v, input logic mode,
                      input int hold, input int exp_lat, output logic [0:15] res);
    int guard;
    int lat;
    guard = 0;
    while (!ir[k] && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    chk("in_ready_wait", 32'(guard < 100), 32'd1);
    set_din(k, v);
    im[k] = mode;
    iv[k] = 1'b1;
    @(posedge clk);
    q_push(k, model(v, nsz(k), mode));
    #1;
    iv[k] = 1'b0;
    // payload changes after accept must not matter
    set_din(k, ~v);
    im[k] = ~mode;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ov[k] && lat < 100);
    chk("latency", 32'(lat), 32'(exp_lat));
    res = get_od(k);
    for (int h = 0; h < hold; h++) begin
      chk("in_ready_in_done", 32'(ir[k]), 32'd0);
      chk("busy_in_done", 32'(bz[k]), 32'd1);
      iv[k] = 1'b1;
      @(posedge clk); #1;
      iv[k] = 1'b0;
      chk("held_out_valid", 32'(ov[k]), 32'd1);
    end
    ordy[k] = 1'b1;
    @(posedge clk); #1;
    ordy[k] = 1'b0;
    chk("idle_in_ready", 32'(ir[k]), 32'd1);
    chk("idle_out_valid", 32'(ov[k]), 32'd0);
    chk("idle_busy", 32'(bz[k]), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [0:15] r;
    logic [0:15] r2;
    logic [0:15] v;
    logic m;
    iv = '0; im = '0; ordy = '0;
    d8 = '0; d16a = '0; d16b = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int k = 0; k < 3; k++) begin
      chk("rst_in_ready", 32'(ir[k]), 32'd1);
      chk("rst_out_valid", 32'(ov[k]), 32'd0);
      chk("rst_busy", 32'(bz[k]), 32'd0);
      chk("rst_out_data", get_od(k), 32'd0);
    end

    // N=8 hand-computed vectors (upper byte holds elements 0..7)
    xfer(0, 16'h8000, 1'b0, 0, 3, r); chk("n8_m0_e0", r, 16'hFF00);
    xfer(0, 16'h0100, 1'b0, 0, 3, r); chk("n8_m0_e7", r, 16'h0100);
    xfer(0, 16'h0100, 1'b1, 0, 3, r); chk("n8_m1_e7", r, 16'hFF00);
    xfer(0, 16'h8000, 1'b1, 0, 3, r); chk("n8_m1_e0", r, 16'h8000);
    xfer(0, 16'hC000, 1'b0, 0, 3, r); chk("n8_m0_c0", r, 16'hAA00);
    xfer(0, r,        1'b0, 0, 3, r); chk("n8_involution", r, 16'hC000);

    // back-pressure: 10 stalled cycles in DONE with in_valid pulses
    xfer(0, 16'h3600, 1'b1, 10, 3, r);
    chk("n8_bp_result", r, model(16'h3600, 8, 1'b1));

    // N=16 random vectors, both modes, plus involution
    for (int t = 0; t < 6; t++) begin
      v = 16'($urandom_range(0, 65535));
      m = t[0];
      xfer(1, v, m, 0, 2, r);
      xfer(1, r, m, 0, 2, r2);
      chk("n16_s2_involution", r2, v);
      v = 16'($urandom_range(0, 65535));
      xfer(2, v, m, 0, 1, r);
      xfer(2, r, m, 0, 1, r2);
      chk("n16_s4_involution", r2, v);
    end

    // mid-run reset at stage_cnt = 1
    iv[0] = 1'b1; im[0] = 1'b0; d8 = 8'hFF;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q_flush();
    chk("mid_rst_out_valid", 32'(ov[0]), 32'd0);
    chk("mid_rst_out_data", 32'(od8), 32'd0);
    chk("mid_rst_in_ready", 32'(ir[0]), 32'd1);
    chk("mid_rst_busy", 32'(bz[0]), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("mid_rst_no_output", 32'(ov[0]), 32'd0);
    xfer(0, 16'h4000, 1'b0, 0, 3, r); chk("n8_after_rst", r, 16'h5500);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
